// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester and data-memory signal bundle for the arbiter
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;
    logic              cpu_stall;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              lock1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1, lock1,
        input  mem_rdata,
        output gnt0, rvalid0, rdata0, cpu_stall,
        output gnt1, rvalid1, rdata1,
        output mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1, lock1,
        output mem_rdata,
        input  gnt0, rvalid0, rdata0, cpu_stall,
        input  gnt1, rvalid1, rdata1,
        input  mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - CPU-priority data-memory arbiter with loader starvation guard and locked bursts
module data_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic                i_clock,
    input  logic                i_reset,
    data_mem_arbiter_if.slave   bus
);
    localparam logic [7:0] LP_STARVE = 8'(STARVE_LIMIT);
    localparam logic [7:0] LP_BURST  = 8'(MAX_BURST);

    typedef enum logic {
        S_IDLE,
        S_LBURST
    } state_t;

    state_t            r_state;
    logic [7:0]        r_starve_cnt;
    logic [7:0]        r_burst_cnt;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic w_gnt0;
    logic w_gnt1;

    // Grants are forced low while reset is held so no command reaches memory.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_reset) begin
            if (r_state == S_LBURST && bus.req1 && bus.lock1) begin
                if (r_burst_cnt == LP_BURST && bus.req0) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else if (r_starve_cnt == LP_STARVE && bus.req1) begin
                w_gnt1 = 1'b1;
            end else if (bus.req0) begin
                w_gnt0 = 1'b1;
            end else if (bus.req1) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.cpu_stall = bus.req0 & ~w_gnt0;
    assign bus.mem_addr  = w_gnt0 ? bus.addr0  : (w_gnt1 ? bus.addr1  : '0);
    assign bus.mem_wdata = w_gnt0 ? bus.wdata0 : (w_gnt1 ? bus.wdata1 : '0);
    assign bus.mem_write = (w_gnt0 & bus.we0) | (w_gnt1 & bus.we1);
    assign bus.mem_read  = (w_gnt0 & ~bus.we0) | (w_gnt1 & ~bus.we1);
    assign bus.rvalid0   = r_rvalid0;
    assign bus.rvalid1   = r_rvalid1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= 8'd0;
            r_burst_cnt  <= 8'd0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~bus.we0;
            r_rvalid1 <= w_gnt1 & ~bus.we1;
            if (w_gnt0 && !bus.we0) begin
                r_rdata0 <= bus.mem_rdata;
            end
            if (w_gnt1 && !bus.we1) begin
                r_rdata1 <= bus.mem_rdata;
            end

            // Any cycle without a locked loader grant (drop, unlock, preemption) ends the burst.
            if (w_gnt1 && bus.lock1) begin
                r_state <= S_LBURST;
                if (r_state == S_IDLE) begin
                    r_burst_cnt <= 8'd1;
                end else if (r_burst_cnt != LP_BURST) begin
                    r_burst_cnt <= r_burst_cnt + 8'd1;
                end
            end else begin
                r_state     <= S_IDLE;
                r_burst_cnt <= 8'd0;
            end

            if (bus.req1 && !w_gnt1) begin
                if (r_starve_cnt != LP_STARVE) begin
                    r_starve_cnt <= r_starve_cnt + 8'd1;
                end
            end else begin
                r_starve_cnt <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter with directed and random traffic
module tb_data_mem_arbiter;
    localparam int STARVE_LIMIT = 8;
    localparam int MAX_BURST    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_arbiter_if bus ();

    data_mem_arbiter #(
        .ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus.slave)
    );

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int last_g   = -1;
    int m_denied = 0;
    int m_locked = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: loader tracked as "cycles waited" and "length of locked run".
    always @(negedge clk) begin
        int eg;
        eg = -1;
        if (!rst) begin
            if (m_locked > 0 && bus.req1 && bus.lock1)
                eg = (m_locked >= MAX_BURST && bus.req0) ? 0 : 1;
            else if (m_denied >= STARVE_LIMIT && bus.req1) eg = 1;
            else if (bus.req0) eg = 0;
            else if (bus.req1) eg = 1;
        end
        chk("gnt0", 32'(bus.gnt0), 32'(eg == 0));
        chk("gnt1", 32'(bus.gnt1), 32'(eg == 1));
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.req0 && eg != 0));
        chk("mem_addr", 32'(bus.mem_addr),
            eg == 0 ? 32'(bus.addr0) : (eg == 1 ? 32'(bus.addr1) : 32'd0));
        chk("mem_wdata", bus.mem_wdata, eg == 0 ? bus.wdata0 : (eg == 1 ? bus.wdata1 : 32'd0));
        chk("mem_write", 32'(bus.mem_write),
            32'((eg == 0 && bus.we0) || (eg == 1 && bus.we1)));
        chk("mem_read", 32'(bus.mem_read),
            32'((eg == 0 && !bus.we0) || (eg == 1 && !bus.we1)));
        if (eg == 0) begin
            if (bus.we0) ref_mem[bus.addr0] = bus.wdata0;
            else q0.push_back(ref_mem[bus.addr0]);
        end else if (eg == 1) begin
            if (bus.we1) ref_mem[bus.addr1] = bus.wdata1;
            else q1.push_back(ref_mem[bus.addr1]);
        end
        if (rst) begin
            m_denied = 0;
            m_locked = 0;
        end else begin
            m_locked = (eg == 1 && bus.lock1) ? ((m_locked < MAX_BURST) ? m_locked + 1 : MAX_BURST) : 0;
            m_denied = (bus.req1 && eg != 1) ?
                       ((m_denied < STARVE_LIMIT) ? m_denied + 1 : STARVE_LIMIT) : 0;
        end
        last_g = eg;
    end

    always @(posedge clk) begin
        #2;
        if (bus.rvalid0) begin
            if (q0.size() == 0) chk("rvalid0_unexpected", 32'(bus.rvalid0), 32'd0);
            else chk("rdata0", bus.rdata0, q0.pop_front());
        end else if (q0.size() != 0) begin
            chk("rvalid0_missing", 32'(bus.rvalid0), 32'd1);
            q0.delete();
        end
        if (bus.rvalid1) begin
            if (q1.size() == 0) chk("rvalid1_unexpected", 32'(bus.rvalid1), 32'd0);
            else chk("rdata1", bus.rdata1, q1.pop_front());
        end else if (q1.size() != 0) begin
            chk("rvalid1_missing", 32'(bus.rvalid1), 32'd1);
            q1.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.lock1 = 0;
    endtask

    task automatic check_regs_zero(input string tag);
        chk({tag, "_rvalid0"}, 32'(bus.rvalid0), 32'd0);
        chk({tag, "_rvalid1"}, 32'(bus.rvalid1), 32'd0);
        chk({tag, "_rdata0"}, bus.rdata0, 32'd0);
        chk({tag, "_rdata1"}, bus.rdata1, 32'd0);
    endtask

    task automatic rand_drive();
        if (!bus.req0 || last_g == 0) begin
            bus.req0   = ($urandom % 3) != 0;
            bus.we0    = 1'($urandom % 2);
            bus.addr0  = 16'($urandom % 16);
            bus.wdata0 = $urandom;
        end else if ($urandom % 16 == 0) begin
            bus.req0 = 0;
        end
        if (!bus.req1 || last_g == 1) begin
            bus.req1   = ($urandom % 4) != 0;
            bus.we1    = 1'($urandom % 2);
            bus.addr1  = 16'($urandom % 16);
            bus.wdata1 = $urandom;
            bus.lock1  = ($urandom % 4) != 0;
        end else if ($urandom % 16 == 0) begin
            bus.req1 = 0;
        end
    endtask

    initial begin
        int n;
        logic [1:0] seq [0:4];
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        idle_inputs();
        repeat (3) step();
        check_regs_zero("reset");
        rst = 0;
        step();

        // CPU write then read of the same word
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h0010; bus.wdata0 = 32'hDEADBEEF;
        step();
        bus.we0 = 0;
        step();
        bus.req0 = 0;
        repeat (3) step();

        // Contention without lock: one loader slot every STARVE_LIMIT+1 cycles
        n = 0;
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h0001; bus.wdata0 = 32'h1111_0000;
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0002; bus.wdata1 = 32'h2222_0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n += int'(bus.gnt1);
            step();
        end
        chk("contention_gnt1_count", 32'(n), 32'd2);
        idle_inputs();
        repeat (2) step();

        // Locked loader burst of six writes
        n = 0;
        for (int i = 0; i < 6; i++) begin
            bus.req1 = 1; bus.lock1 = 1; bus.we1 = 1;
            bus.addr1 = 16'(i); bus.wdata1 = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            n += int'(bus.gnt1);
            step();
        end
        idle_inputs();
        chk("burst_gnt1_count", 32'(n), 32'd6);
        step();
        for (int i = 0; i < 6; i++) chk("burst_mem", mem[i], 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 6; i++) begin
            bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'(i);
            step();
        end
        idle_inputs();
        repeat (2) step();

        // Preemption of a locked burst once it reaches MAX_BURST
        bus.req1 = 1; bus.lock1 = 1; bus.we1 = 1; bus.addr1 = 16'h0020; bus.wdata1 = 32'h0000_0055;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0020;
            end
            @(negedge clk);
            seq[i] = {bus.gnt0, bus.gnt1};
            step();
        end
        bus.req0 = 0;
        for (int i = 0; i < 5; i++) chk("preempt_seq", 32'(seq[i]), (i == 4) ? 32'd2 : 32'd1);
        step();
        idle_inputs();
        repeat (2) step();

        // Reset in the cycle after a granted CPU read drops the return
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0010;
        step();
        rst = 1;
        q0.delete();
        q1.delete();
        #1;
        check_regs_zero("reset_mid_read");
        chk("reset_gnt0", 32'(bus.gnt0), 32'd0);
        repeat (2) step();
        rst = 0;
        step();
        bus.req0 = 0;
        repeat (2) step();

        // Idle
        repeat (5) step();

        for (int i = 0; i < 3000; i++) begin
            rand_drive();
            step();
        end
        idle_inputs();
        repeat (4) step();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
